ser_tx_arbiter: RTL and testbench



---
 rtl/ser_arb_pkg.sv | 23 ++
 rtl/ser_tx_arbiter_if.sv | 21 ++
 rtl/ser_arb_pick.sv | 43 ++++
 rtl/ser_tx_arbiter.sv | 154 +++++++++++++++
 tb/tb_ser_tx_arbiter.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/ser_arb_pkg.sv
// Shared types and helpers for the serial write-channel arbiter.
// Used by ser_tx_arbiter, ser_arb_pick and ser_tx_arbiter_if.
package ser_arb_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  // Never returns less than 1, so counters of size 1 still get a real bit.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ser_tx_arbiter_if.sv
// Requester-side and serial-side signals of ser_tx_arbiter.
// req[i] is a level held (with din[i] stable) until the one-cycle gnt[i] pulse accepts the byte.
interface ser_tx_arbiter_if #(
  parameter int NREQ = 4
);
  import ser_arb_pkg::*;

  localparam int IW = clog2(NREQ);

  logic [NREQ-1:0]        req;
  logic [NREQ*BYTE_W-1:0] din;
  logic [NREQ-1:0]        gnt;
  logic [IW-1:0]          owner;
  logic                   busy;
  logic                   wra_n;
  logic                   da;

  modport master (output req, din, input gnt, owner, busy, wra_n, da);
  modport slave  (input req, din, output gnt, owner, busy, wra_n, da);

endinterface

// File: rtl/ser_arb_pick.sv
// Combinational NREQ-way request picker.
// SER_ARB_RR_EN: round-robin starting after ptr; otherwise fixed priority, lowest index wins.
module ser_arb_pick
  import ser_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic            valid,
  output logic [IW-1:0]   win
);

`ifdef SER_ARB_RR_EN
  // Walk from the farthest candidate to the nearest so the nearest after ptr wins.
  always_comb begin
    valid = 1'b0;
    win   = '0;
    for (int k = NREQ; k >= 1; k--) begin
      if (req[(int'(ptr) + k) % NREQ]) begin
        valid = 1'b1;
        win   = IW'((int'(ptr) + k) % NREQ);
      end
    end
  end
`else
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin
    valid = 1'b0;
    win   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        win   = IW'(i);
      end
    end
  end
`endif

endmodule

// File: rtl/ser_tx_arbiter.sv
// Arbitrates NREQ byte requesters onto one wra_n/da serial write channel, 8 bits then GAP idle cycles.
// Optional macro SER_ARB_RR_EN selects round-robin instead of fixed-priority arbitration.
module ser_tx_arbiter
  import ser_arb_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int GAP       = 2,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clka,
  input  logic              rst,
  ser_tx_arbiter_if.slave   bus,
  output state_e            dbg_state
);

  localparam int IW = clog2(NREQ);
  localparam int GW = clog2(GAP);

  state_e              state_q, state_d;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic [GW-1:0]       gap_cnt_q, gap_cnt_d;
  logic [BYTE_W-1:0]   byte_q, byte_d;
  logic [NREQ-1:0]     gnt_q, gnt_d;
  logic [IW-1:0]       owner_q, owner_d;
  logic                busy_q, busy_d;
  logic                wra_n_q, wra_n_d;
  logic                da_q, da_d;
  logic [IW-1:0]       ptr_q;

  logic                arb, start, pick_valid;
  logic [IW-1:0]       pick_win;
  logic [BYTE_W-1:0]   win_byte;
  logic [2:0]          bit_nxt;

  ser_arb_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req   (bus.req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .win   (pick_win)
  );

  assign arb      = (state_q == ST_IDLE) ||
                    ((state_q == ST_GAP) && (gap_cnt_q == GW'(GAP - 1)));
  assign start    = arb && pick_valid;
  assign win_byte = bus.din[pick_win*BYTE_W +: BYTE_W];
  assign bit_nxt  = bit_cnt_q + 3'd1;

`ifdef SER_ARB_RR_EN
  logic [IW-1:0] ptr_d;
  assign ptr_d = start ? pick_win : ptr_q;

  always_ff @(posedge clka) begin
    if (rst) ptr_q <= IW'(NREQ - 1);
    else     ptr_q <= ptr_d;
  end
`else
  assign ptr_q = IW'(NREQ - 1);
`endif

  // State register plus all registered outputs and datapath.
  always_ff @(posedge clka) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      byte_q    <= '0;
      gnt_q     <= '0;
      owner_q   <= '0;
      busy_q    <= 1'b0;
      wra_n_q   <= 1'b1;
      da_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      byte_q    <= byte_d;
      gnt_q     <= gnt_d;
      owner_q   <= owner_d;
      busy_q    <= busy_d;
      wra_n_q   <= wra_n_d;
      da_q      <= da_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = ST_SHIFT;
    end else begin
      case (state_q)
        ST_IDLE:  state_d = ST_IDLE;
        ST_SHIFT: if (bit_cnt_q == 3'd7) state_d = ST_GAP;
        ST_GAP:   if (arb) state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // The first bit is driven in the same cycle as gnt; later bits index the held byte.
  always_comb begin
    gnt_d     = '0;
    owner_d   = owner_q;
    busy_d    = busy_q;
    wra_n_d   = wra_n_q;
    da_d      = da_q;
    byte_d    = byte_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    if (start) begin
      gnt_d[pick_win] = 1'b1;
      byte_d          = win_byte;
      owner_d         = pick_win;
      busy_d          = 1'b1;
      wra_n_d         = 1'b0;
      da_d            = MSB_FIRST ? win_byte[BYTE_W-1] : win_byte[0];
      bit_cnt_d       = '0;
    end else begin
      case (state_q)
        ST_SHIFT: begin
          if (bit_cnt_q == 3'd7) begin
            wra_n_d   = 1'b1;
            da_d      = 1'b0;
            gap_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_nxt;
            da_d      = byte_q[MSB_FIRST ? ~bit_nxt : bit_nxt];
          end
        end
        ST_GAP: begin
          if (arb) begin
            busy_d  = 1'b0;
            wra_n_d = 1'b1;
            da_d    = 1'b0;
          end else begin
            gap_cnt_d = gap_cnt_q + 1'b1;
          end
        end
        default: begin
          busy_d  = 1'b0;
          wra_n_d = 1'b1;
          da_d    = 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.owner = owner_q;
  assign bus.busy  = busy_q;
  assign bus.wra_n = wra_n_q;
  assign bus.da    = da_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ser_tx_arbiter.sv
// Directed bench: an MSB-first and an LSB-first arbiter share identical stimulus.
// Expected grant order follows SER_ARB_RR_EN (round-robin) or fixed priority.
module tb_ser_tx_arbiter;
  import ser_arb_pkg::*;

  localparam int NREQ = 4;
  localparam int GAP  = 2;

  logic        clka;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] din;
  state_e      st_a, st_b;

  int n_chk;
  int n_fail;
  int seq4[4];
  int seq5[5];

  ser_tx_arbiter_if #(.NREQ(NREQ)) bus_a ();
  ser_tx_arbiter_if #(.NREQ(NREQ)) bus_b ();

  assign bus_a.req = req;
  assign bus_a.din = din;
  assign bus_b.req = req;
  assign bus_b.din = din;

  ser_tx_arbiter #(.NREQ(NREQ), .GAP(GAP), .MSB_FIRST(1'b1)) u_msb (
    .clka(clka), .rst(rst), .bus(bus_a), .dbg_state(st_a)
  );

  ser_tx_arbiter #(.NREQ(NREQ), .GAP(GAP), .MSB_FIRST(1'b0)) u_lsb (
    .clka(clka), .rst(rst), .bus(bus_b), .dbg_state(st_b)
  );

  // clock / reset
  initial clka = 1'b0;
  always #5 clka = ~clka;

  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_wra_n_a"}, 32'(bus_a.wra_n), 32'd1);
    chk({tag, "_wra_n_b"}, 32'(bus_b.wra_n), 32'd1);
    chk({tag, "_busy"},    32'(bus_a.busy),  32'd0);
    chk({tag, "_gnt"},     32'(bus_a.gnt),   32'd0);
    chk({tag, "_state"},   32'(st_a),        32'(ST_IDLE));
  endtask

  // Checks one byte from its grant cycle through the end of its gap.
  task automatic burst(input int w, input logic [7:0] b, input bit late);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick();
      chk("gnt_a",   32'(bus_a.gnt),   (i == 0) ? (32'd1 << w) : 32'd0);
      chk("gnt_b",   32'(bus_b.gnt),   (i == 0) ? (32'd1 << w) : 32'd0);
      chk("wra_n_a", 32'(bus_a.wra_n), 32'd0);
      chk("wra_n_b", 32'(bus_b.wra_n), 32'd0);
      chk("da_msb",  32'(bus_a.da),    32'(b[7-i]));
      chk("da_lsb",  32'(bus_b.da),    32'(b[i]));
      chk("owner_a", 32'(bus_a.owner), 32'(w));
      chk("owner_b", 32'(bus_b.owner), 32'(w));
      chk("busy",    32'(bus_a.busy),  32'd1);
      if (late && i == 2) begin
        req[3]     = 1'b1;
        din[7:0]   = ~din[7:0];
        din[31:24] = 8'h5A;
      end
    end
    for (int g = 0; g < GAP; g++) begin
      tick();
      chk("gap_wra_n_a", 32'(bus_a.wra_n), 32'd1);
      chk("gap_wra_n_b", 32'(bus_b.wra_n), 32'd1);
      chk("gap_da",      32'(bus_a.da),    32'd0);
      chk("gap_busy",    32'(bus_a.busy),  32'd1);
      chk("gap_gnt",     32'(bus_a.gnt | bus_b.gnt), 32'd0);
      chk("gap_state",   32'(st_a),        32'(ST_GAP));
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
`ifdef SER_ARB_RR_EN
    seq4 = '{0, 2, 0, 2};
    seq5 = '{0, 1, 2, 3, 0};
`else
    seq4 = '{0, 0, 0, 0};
    seq5 = '{0, 0, 0, 0, 0};
`endif
    rst = 1'b1;
    req = '0;
    din = '0;
    tick();
    tick();
    chk_idle("rst");
    chk("rst_da",    32'(bus_a.da),    32'd0);
    chk("rst_owner", 32'(bus_a.owner), 32'd0);
    rst = 1'b0;
    tick();
    chk_idle("idle");

    // single byte, one-cycle latency from IDLE
    din[7:0] = 8'hA5;
    req      = 4'b0001;
    tick();
    req = '0;
    burst(0, 8'hA5, 1'b0);
    tick();
    chk_idle("single_end");

    // late request and din change during another byte's SHIFT
    din[7:0] = 8'h3C;
    req      = 4'b0001;
    tick();
    req[0] = 1'b0;
    burst(0, 8'h3C, 1'b1);
    tick();
    req = '0;
    burst(3, 8'h5A, 1'b0);
    tick();
    chk_idle("late_end");

    // back-to-back with req[0] and req[2] held
    din   = 32'h00C3_003C;
    req   = 4'b0101;
    tick();
    for (int n = 0; n < 4; n++) begin
      if (n > 0) tick();
      burst(seq4[n], (seq4[n] == 0) ? 8'h3C : 8'hC3, 1'b0);
    end
    req = '0;
    tick();
    chk_idle("b2b_end");

    // reset together with requests: reset wins, then all four from reset
    din = 32'h4433_2211;
    req = 4'b1111;
    rst = 1'b1;
    tick();
    chk_idle("rst_req");
    rst = 1'b0;
    tick();
    for (int n = 0; n < 5; n++) begin
      if (n > 0) tick();
      burst(seq5[n], din[seq5[n]*8 +: 8], 1'b0);
    end
    req = '0;
    tick();
    chk_idle("all4_end");

    // reset during bit 4 aborts the byte
    din[7:0] = 8'hA5;
    req      = 4'b0001;
    tick();
    req = '0;
    for (int i = 0; i < 4; i++) tick();
    chk("bit4_wra_n", 32'(bus_a.wra_n), 32'd0);
    rst = 1'b1;
    tick();
    chk_idle("abort");
    chk("abort_owner", 32'(bus_a.owner), 32'd0);
    rst        = 1'b0;
    din[15:8]  = 8'hFF;
    req        = 4'b0010;
    tick();
    req = '0;
    burst(1, 8'hFF, 1'b0);
    tick();
    chk_idle("after_abort");

    // LSB-first single 8'h01 (MSB DUT sees it reversed)
    din[7:0] = 8'h01;
    req      = 4'b0001;
    tick();
    req = '0;
    burst(0, 8'h01, 1'b0);
    tick();
    chk_idle("lsb_end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
